// File: rtl/stage_mult_arbiter.sv
// stage_mult_arbiter
//   Shares one stage_mult (four-lane complex multiply, sum of products,
//   fixed LATENCY) between two requesters. Round-robin with a bounded burst
//   length decides who drives the multiplier each cycle. A tag delay line
//   follows each beat through the multiplier so that every 64-bit result is
//   returned to the requester that issued it. Strobe/tag disagreements are
//   latched into sticky error flags.
//
// Ports
//   clock, reset          single clock, synchronous active-high reset
//   enable                high allows new grants; in-flight beats always drain
//   reqN_valid/reqN_ready beat handshake per requester (ready is combinational)
//   reqN_x, reqN_y        operands X0..X7 / Y0..Y7, X0 at [15:0]
//   mult_x, mult_y        registered operands towards stage_mult
//   mult_strobe           registered input strobe towards stage_mult
//   mult_enable           registered, equals ~reset
//   mult_sum              stage_mult result (I [63:32], Q [31:0])
//   mult_out_strobe       stage_mult output strobe
//   res_sum               registered result shared by both requesters
//   resN_strobe           one-cycle strobe: res_sum belongs to requester N
//   err_orphan            sticky: result strobe with no tag at the head
//   err_missing           sticky: tag at the head with no result strobe
module stage_mult_arbiter #(
  parameter int LATENCY   = 5,
  parameter int MAX_BURST = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         enable,
  input  logic         req0_valid,
  input  logic         req1_valid,
  output logic         req0_ready,
  output logic         req1_ready,
  input  logic [127:0] req0_x,
  input  logic [127:0] req0_y,
  input  logic [127:0] req1_x,
  input  logic [127:0] req1_y,
  output logic [127:0] mult_x,
  output logic [127:0] mult_y,
  output logic         mult_strobe,
  output logic         mult_enable,
  input  logic [63:0]  mult_sum,
  input  logic         mult_out_strobe,
  output logic [63:0]  res_sum,
  output logic         res0_strobe,
  output logic         res1_strobe,
  output logic         err_orphan,
  output logic         err_missing
);

  localparam int BW = (MAX_BURST < 1) ? 1 : $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] BURST_MAX  = BW'(MAX_BURST);
  localparam logic [BW-1:0] BURST_ONE  = BW'(1);
  localparam logic [BW-1:0] BURST_ZERO = BW'(0);

  // Issue stage (this is also the entry point of the tag line)
  logic [127:0]        r_mult_x;
  logic [127:0]        r_mult_y;
  logic                r_mult_strobe;
  logic                r_mult_id;
  logic                r_mult_enable;

  // Arbitration state
  logic                r_owner;
  logic [BW-1:0]       r_burst_cnt;

  // Tag line; together with the issue register it spans the multiplier's
  // LATENCY so the head lines up with mult_out_strobe
  logic [LATENCY-1:0]  r_tag_valid;
  logic [LATENCY-1:0]  r_tag_id;

  // Result and error registers
  logic [63:0]         r_res_sum;
  logic                r_res0_strobe;
  logic                r_res1_strobe;
  logic                r_err_orphan;
  logic                r_err_missing;

  logic                w_grant0;
  logic                w_grant1;
  logic                w_grant;
  logic                w_grant_id;
  logic [127:0]        w_sel_x;
  logic [127:0]        w_sel_y;
  logic                w_head_valid;
  logic                w_head_id;

  // Grant decision: round-robin with bounded burst, blocked by enable/reset
  always_comb begin
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    if (enable && !reset) begin
      case ({req1_valid, req0_valid})
        2'b01: w_grant0 = 1'b1;
        2'b10: w_grant1 = 1'b1;
        2'b11: begin
          // Owner keeps the grant until it has used up its burst
          if (r_burst_cnt < BURST_MAX) begin
            w_grant0 = ~r_owner;
            w_grant1 = r_owner;
          end else begin
            w_grant0 = r_owner;
            w_grant1 = ~r_owner;
          end
        end
        default: begin
          w_grant0 = 1'b0;
          w_grant1 = 1'b0;
        end
      endcase
    end else begin
      w_grant0 = 1'b0;
      w_grant1 = 1'b0;
    end
  end

  assign w_grant    = w_grant0 | w_grant1;
  assign w_grant_id = w_grant1;

  // Operand select for the granted requester
  always_comb begin
    w_sel_x = req0_x;
    w_sel_y = req0_y;
    if (w_grant1) begin
      w_sel_x = req1_x;
      w_sel_y = req1_y;
    end else begin
      w_sel_x = req0_x;
      w_sel_y = req0_y;
    end
  end

  assign w_head_valid = r_tag_valid[LATENCY-1];
  assign w_head_id    = r_tag_id[LATENCY-1];

  // Issue stage: operands, strobe and owner id of the beat entering the multiplier
  always_ff @(posedge clock) begin
    if (reset) begin
      r_mult_x      <= 128'd0;
      r_mult_y      <= 128'd0;
      r_mult_strobe <= 1'b0;
      r_mult_id     <= 1'b0;
      r_mult_enable <= 1'b0;
    end else begin
      r_mult_enable <= 1'b1;
      r_mult_strobe <= w_grant;
      if (w_grant) begin
        r_mult_x  <= w_sel_x;
        r_mult_y  <= w_sel_y;
        r_mult_id <= w_grant_id;
      end else begin
        r_mult_x  <= r_mult_x;
        r_mult_y  <= r_mult_y;
        r_mult_id <= 1'b0;
      end
    end
  end

  // Arbitration state: owner and consecutive-beat counter
  always_ff @(posedge clock) begin
    if (reset) begin
      r_owner     <= 1'b0;
      r_burst_cnt <= BURST_ZERO;
    end else if (w_grant) begin
      if (w_grant_id == r_owner) begin
        if (r_burst_cnt != BURST_MAX) begin
          r_burst_cnt <= r_burst_cnt + BURST_ONE;
        end else begin
          r_burst_cnt <= r_burst_cnt;
        end
      end else begin
        r_owner     <= w_grant_id;
        r_burst_cnt <= BURST_ONE;
      end
    end else begin
      // Any idle cycle ends the burst; the owner is remembered
      r_burst_cnt <= BURST_ZERO;
    end
  end

  // Tag line: shifts every cycle so in-flight beats drain regardless of enable
  always_ff @(posedge clock) begin
    if (reset) begin
      r_tag_valid <= {LATENCY{1'b0}};
      r_tag_id    <= {LATENCY{1'b0}};
    end else begin
      r_tag_valid[0] <= r_mult_strobe;
      r_tag_id[0]    <= r_mult_id;
      for (int i = 1; i < LATENCY; i++) begin
        r_tag_valid[i] <= r_tag_valid[i-1];
        r_tag_id[i]    <= r_tag_id[i-1];
      end
    end
  end

  // Result return: route the multiplier output to the owner of the head tag
  always_ff @(posedge clock) begin
    if (reset) begin
      r_res_sum     <= 64'd0;
      r_res0_strobe <= 1'b0;
      r_res1_strobe <= 1'b0;
    end else begin
      r_res0_strobe <= mult_out_strobe & w_head_valid & ~w_head_id;
      r_res1_strobe <= mult_out_strobe & w_head_valid & w_head_id;
      if (mult_out_strobe && w_head_valid) begin
        r_res_sum <= mult_sum;
      end else begin
        r_res_sum <= r_res_sum;
      end
    end
  end

  // Sticky mismatch flags between the tag head and the multiplier strobe
  always_ff @(posedge clock) begin
    if (reset) begin
      r_err_orphan  <= 1'b0;
      r_err_missing <= 1'b0;
    end else begin
      r_err_orphan  <= r_err_orphan  | (mult_out_strobe & ~w_head_valid);
      r_err_missing <= r_err_missing | (w_head_valid & ~mult_out_strobe);
    end
  end

  assign req0_ready  = w_grant0;
  assign req1_ready  = w_grant1;
  assign mult_x      = r_mult_x;
  assign mult_y      = r_mult_y;
  assign mult_strobe = r_mult_strobe;
  assign mult_enable = r_mult_enable;
  assign res_sum     = r_res_sum;
  assign res0_strobe = r_res0_strobe;
  assign res1_strobe = r_res1_strobe;
  assign err_orphan  = r_err_orphan;
  assign err_missing = r_err_missing;

endmodule
